// File: rtl/mem_ctrl_pkg.sv
// Shared constants, types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned RegBus      = 32;
    localparam int unsigned MemLenBus   = 2;

    localparam logic [RegBus-1:0]    ZeroWord   = 32'h0000_0000;
    localparam logic [MemLenBus-1:0] MemLenByte = 2'b00;
    localparam logic [MemLenBus-1:0] MemLenHalf = 2'b01;
    localparam logic [MemLenBus-1:0] MemLenWord = 2'b10;

    typedef enum logic [1:0] {
        MemCtrlIdle = 2'd0,
        MemCtrlRd   = 2'd1,
        MemCtrlWr   = 2'd2
    } state_e;

    typedef enum logic {
        OwnerIf  = 1'b0,
        OwnerMem = 1'b1
    } owner_e;

    // Byte count of an access; the reserved encoding 11 behaves as a word.
    function automatic logic [2:0] len_to_n(input logic [MemLenBus-1:0] len);
        logic [2:0] n;
        unique case (len)
            MemLenByte: n = 3'd1;
            MemLenHalf: n = 3'd2;
            MemLenWord: n = 3'd4;
            default:    n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side request ports and RAM-side byte bus of the memory controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    // Instruction fetch port
    logic                   if_req_i;
    logic [InstAddrBus-1:0] if_addr_i;
    logic                   if_flush_i;
    logic                   if_done_o;
    logic [RegBus-1:0]      if_data_o;

    // Load/store port
    logic                   mem_req_i;
    logic                   mem_we_i;
    logic [RegBus-1:0]      mem_addr_i;
    logic [MemLenBus-1:0]   mem_len_i;
    logic [RegBus-1:0]      mem_wdata_i;
    logic                   mem_done_o;
    logic [RegBus-1:0]      mem_rdata_o;

    // Byte-wide synchronous RAM
    logic [RegBus-1:0]      ram_addr_o;
    logic                   ram_wr_o;
    logic [7:0]             ram_dout_o;
    logic [7:0]             ram_din_i;

    // Controller side
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
        input  ram_din_i,
        output if_done_o, if_data_o,
        output mem_done_o, mem_rdata_o,
        output ram_addr_o, ram_wr_o, ram_dout_o
    );

    // Requester / RAM side
    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
        output ram_din_i,
        input  if_done_o, if_data_o,
        input  mem_done_o, mem_rdata_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM between instruction fetch and load/store,
// serialising each access into little-endian byte transactions.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [RegBus-1:0] base_q, base_d;
    logic [RegBus-1:0] wdata_q, wdata_d;
    logic [RegBus-1:0] buf_q, buf_d;
    logic [RegBus-1:0] if_data_q, if_data_d;
    logic [RegBus-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    logic              mem_take;
    logic              if_take;
    logic [1:0]        lane;
    logic [RegBus-1:0] buf_cap;
    logic [RegBus-1:0] rd_off;

    // Assembly buffer with the incoming RAM byte merged into lane cnt-1
    always_comb begin
        lane    = cnt_q[1:0] - 2'd1;
        buf_cap = buf_q;
        buf_cap[{lane, 3'b000} +: 8] = bus.ram_din_i;
    end

    // RAM bus decode from state/cnt only, so no request reaches the RAM combinationally
    always_comb begin
        bus.ram_addr_o = ZeroWord;
        bus.ram_wr_o   = 1'b0;
        bus.ram_dout_o = 8'h00;
        rd_off         = {29'd0, cnt_q};
        unique case (state_q)
            MemCtrlRd: begin
                // Final capture cycle keeps the last byte address on the bus
                if (cnt_q == n_q) begin
                    rd_off = {29'd0, n_q - 3'd1};
                end
                bus.ram_addr_o = base_q + rd_off;
            end
            MemCtrlWr: begin
                bus.ram_wr_o   = 1'b1;
                bus.ram_addr_o = base_q + {29'd0, cnt_q};
                bus.ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Arbitration, byte sequencing and result capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        // A port still showing done is holding a stale request
        mem_take = bus.mem_req_i && !mem_done_q;
        if_take  = bus.if_req_i && !if_done_q && !bus.if_flush_i;

        unique case (state_q)
            MemCtrlIdle: begin
                if (mem_take) begin
                    owner_d = OwnerMem;
                    base_d  = bus.mem_addr_i;
                    n_d     = len_to_n(bus.mem_len_i);
                    wdata_d = bus.mem_wdata_i;
                    buf_d   = ZeroWord;
                    cnt_d   = 3'd0;
                    state_d = bus.mem_we_i ? MemCtrlWr : MemCtrlRd;
                end else if (if_take) begin
                    owner_d = OwnerIf;
                    base_d  = bus.if_addr_i;
                    n_d     = 3'd4;
                    buf_d   = ZeroWord;
                    cnt_d   = 3'd0;
                    state_d = MemCtrlRd;
                end
            end
            MemCtrlRd: begin
                if (owner_q == OwnerIf && bus.if_flush_i) begin
                    state_d = MemCtrlIdle;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d = buf_cap;
                    end
                    if (cnt_q == n_q) begin
                        state_d = MemCtrlIdle;
                        cnt_d   = 3'd0;
                        if (owner_q == OwnerIf) begin
                            if_done_d = 1'b1;
                            if_data_d = buf_cap;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = buf_cap;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MemCtrlWr: begin
                if (cnt_q == n_q - 3'd1) begin
                    state_d    = MemCtrlIdle;
                    cnt_d      = 3'd0;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = MemCtrlIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= MemCtrlIdle;
            owner_q     <= OwnerIf;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            base_q      <= ZeroWord;
            wdata_q     <= ZeroWord;
            buf_q       <= ZeroWord;
            if_data_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign bus.if_done_o   = if_done_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;

endmodule
